led_pwm_driver: RTL
===================

// Module: led_pwm_driver
// PURPOSE
//   Sits directly downstream of the LED PIO: consumes its 8-bit out_port pattern and drives the board LED pins.
//   Adds global brightness (PWM) and hardware blink, configured over its own Avalon-MM slave on the system bus.
//   Reset default is transparent pass-through, so existing software keeps working unchanged.
// PARAMETERS
//   NUM_LEDS  8   width of led_in / led_out
//   PWM_BITS  8   PWM counter width; one frame = 2**PWM_BITS ticks
//   PRESCALE  50  clk cycles per PWM tick, >=1 (bench uses 4)
// PORTS
//   clk        in   1         system clock, single clock domain
//   reset      in   1         synchronous, active-high reset
//   led_in     in   NUM_LEDS  pattern from LED PIO out_port
//   address    in   2         Avalon register select
//   chipselect in   1         Avalon slave select
//   write_n    in   1         Avalon write strobe, active-low
//   writedata  in   32        Avalon write data
//   readdata   out  32        Avalon read data, combinational, zero wait states
//   led_out    out  NUM_LEDS  registered LED pin drive
// BEHAVIOUR
//   Registers. Write when chipselect & ~write_n; unused bits read 0.
//     0 CTRL   [0] enable, [1] blink_en           reset 0x1
//     1 DUTY   [PWM_BITS:0] brightness            reset 2**PWM_BITS (full on)
//     2 BLINK  [15:0] half-period in PWM frames   reset 1
//     3 STATUS read-only: [0] blink_phase, [PWM_BITS+7:8] pwm_cnt. Writes are ignored.
//   Prescaler pre_cnt: 0..PRESCALE-1, wraps. tick = (pre_cnt==PRESCALE-1).
//   pwm_cnt increments on tick and wraps 2**PWM_BITS-1 -> 0. frame_end = tick & pwm_cnt at max.
//   duty_sh is a shadow of DUTY, loaded only on frame_end, so there is no mid-frame glitch.
//     A DUTY write takes effect from the first frame that starts after the write.
//   pwm_on = (duty_sh >= 2**PWM_BITS) ? 1 : (pwm_cnt < duty_sh). duty_sh 0 means always off.
//   Blink, when blink_en=1:
//     frame_cnt increments on frame_end.
//     When frame_cnt==max(BLINK,1)-1 on frame_end: frame_cnt<=0 and blink_phase toggles.
//     BLINK=0 behaves as BLINK=1.
//   Blink, when blink_en=0: frame_cnt<=0 and blink_phase<=1 every cycle.
//   Setting blink_en 0->1 starts in the on phase with frame_cnt 0.
//   A BLINK write does not clear frame_cnt. If the new value is <= frame_cnt, the count runs to max and wraps through 0.
//   Output register, each cycle: led_out <= (enable & blink_phase & pwm_on) ? led_in : 0.
//     Latency from led_in, DUTY shadow or blink phase to pins is 1 clk.
//   enable=0 forces led_out to 0 from the next cycle. pwm_cnt and the blink counters keep running.
//   Reset (sync, all state):
//     registers take the reset values above
//     pre_cnt=pwm_cnt=frame_cnt=0, blink_phase=1, duty_sh=2**PWM_BITS, led_out=0
//     From the 1st cycle after reset deasserts, led_out follows led_in with 1-clk delay.
//   Reset asserted mid-frame or mid-blink aborts immediately. No partial frame is completed.
//   A write and a frame_end in the same cycle: the register updates and duty_sh loads the OLD DUTY.
//   The new DUTY applies from the next frame_end.
//   Reads of addresses 0-2 return the current register values, including writes from earlier cycles.
// TESTING (PRESCALE=4, frame=1024 clk)
//   1 Reset release, led_in=0xA5 -> led_out=0xA5 one clk later; readdata at addr0=0x1, addr1=0x100, addr2=0x1.
//   2 DUTY=64, led_in=0xFF -> after the next frame_end, each 1024-clk frame has exactly 256 clk of 0xFF then 768 of 0x00.
//   3 DUTY written 0 mid-frame -> the current frame keeps its old duty, then led_out=0 for all later frames.
//     Write at frame_end -> change applies one frame later.
//   4 CTRL=0x3, BLINK=2, DUTY=256 -> led_out=led_in for 2048 clk, then 0 for 2048 clk, repeating.
//     BLINK=0 -> 1024-clk half-period.
//   5 CTRL=0 -> led_out=0 next clk while STATUS pwm_cnt keeps advancing.
//     CTRL=1 -> output resumes with no counter restart.
//   6 Assert reset mid-frame and mid-blink -> pwm_cnt=0, blink_phase=1, led_out=0, registers at reset values.
//     Writes to addr3 are ignored.

Source files
------------

// File: rtl/led_pwm_driver.sv
// LED pin driver behind the LED PIO: global PWM brightness and hardware blink,
// configured through a small Avalon-MM slave. Resets to transparent pass-through.
module led_pwm_driver #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] led_in,
  input  logic [1:0]          address,
  input  logic                chipselect,
  input  logic                write_n,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic [NUM_LEDS-1:0] led_out
);

  localparam int                PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS:0] DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};

  logic                r_enable;
  logic                r_blink_en;
  logic [PWM_BITS:0]   r_duty;
  logic [15:0]         r_blink;
  logic [PRE_W-1:0]    r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS:0]   r_duty_sh;
  logic [15:0]         r_frame_cnt;
  logic                r_blink_phase;
  logic [NUM_LEDS-1:0] r_led_out;

  logic        w_wr;
  logic        w_tick;
  logic        w_frame_end;
  logic        w_pwm_on;
  logic [15:0] w_blink_eff;
  logic        w_blink_last;
  logic        w_unused;

  assign w_wr         = chipselect & ~write_n;
  assign w_tick       = (r_pre_cnt == PRE_MAX);
  assign w_frame_end  = w_tick & (&r_pwm_cnt);
  // Any shadow value with the top bit set is at or above full scale.
  assign w_pwm_on     = r_duty_sh[PWM_BITS] | ({1'b0, r_pwm_cnt} < r_duty_sh);
  assign w_blink_eff  = (r_blink == 16'd0) ? 16'd1 : r_blink;
  assign w_blink_last = (r_frame_cnt == w_blink_eff - 16'd1);
  assign w_unused     = &{1'b0, writedata[31:16]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable      <= 1'b1;
      r_blink_en    <= 1'b0;
      r_duty        <= DUTY_FULL;
      r_blink       <= 16'd1;
      r_pre_cnt     <= '0;
      r_pwm_cnt     <= '0;
      r_duty_sh     <= DUTY_FULL;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
      r_led_out     <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          2'd0: begin
            r_enable   <= writedata[0];
            r_blink_en <= writedata[1];
          end
          2'd1:    r_duty  <= writedata[PWM_BITS:0];
          2'd2:    r_blink <= writedata[15:0];
          default: ;
        endcase
      end

      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick)
        r_pwm_cnt <= r_pwm_cnt + 1'b1;

      // Shadow samples the pre-write DUTY when a write lands on frame_end.
      if (w_frame_end)
        r_duty_sh <= r_duty;

      if (!r_blink_en) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= 1'b1;
      end else if (w_frame_end) begin
        if (w_blink_last) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end

      r_led_out <= (r_enable & r_blink_phase & w_pwm_on) ? led_in : '0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1:0]        = {r_blink_en, r_enable};
      2'd1: readdata[PWM_BITS:0] = r_duty;
      2'd2: readdata[15:0]       = r_blink;
      default: begin
        readdata[0]            = r_blink_phase;
        readdata[PWM_BITS+7:8] = r_pwm_cnt;
      end
    endcase
  end

  assign led_out = r_led_out;

endmodule
